// File: rtl/mux2to1_32.sv
// ----------------------------------------------------------------------------
// mux2to1_32
//
// Two-input word multiplexer used as the IF-stage next-PC select. The
// combinational result feeds the PC register directly. A registered copy of
// the result and of the select is also provided, along with a saturating count
// of how many cycles chose in1.
//
// Parameters
//   WIDTH   : data width of in0, in1, out and out_q (default 32)
//   CNT_W   : width of sel_cnt (default 16)
//
// Ports
//   clk     : in  - single clock, all state updates on the rising edge
//   rst     : in  - synchronous, active-low reset
//   sel     : in  - 0 selects in0 (PC+4), 1 selects in1 (branch target)
//   in0     : in  - data input 0
//   in1     : in  - data input 1
//   out     : out - combinational mux result
//   out_q   : out - out registered, 1-cycle latency
//   sel_q   : out - sel registered, 1-cycle latency
//   sel_cnt : out - saturating count of cycles with sel=1
//
// Instantiate with named port connections; clk and rst come first.
// ----------------------------------------------------------------------------
module mux2to1_32 #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             sel_q,
   output logic [CNT_W-1:0] sel_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Pure select with no clock or reset in the path, so a branch target
   // presented with sel high is visible to the PC register on the same edge.
   always_comb begin
      out = sel ? in1 : in0;
   end

   // NOTE: reset is sampled only inside the clocked block (no rst in the
   // sensitivity list), so rst glitches between edges never reach the flops.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_q   <= '0;
         sel_q   <= 1'b0;
         sel_cnt <= '0;
      end else begin
         out_q <= out;
         sel_q <= sel;
         // Saturate instead of wrapping; hold when sel is low.
         if (sel && (sel_cnt != CNT_MAX)) begin
            sel_cnt <= sel_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mux2to1_32.sv
// ----------------------------------------------------------------------------
// tb_mux2to1_32
//
// Self-checking bench for mux2to1_32. Two instances share stimulus: one with
// default parameters and one with CNT_W=2 to reach counter saturation.
// Expected registered values are pushed to a scoreboard queue when stimulus is
// driven and popped and compared after the following rising edge.
// ----------------------------------------------------------------------------
module tb_mux2to1_32;

   logic        clk;
   logic        rst;
   logic        sel;
   logic [31:0] in0;
   logic [31:0] in1;

   logic [31:0] out,  out_q;
   logic        sel_q;
   logic [15:0] sel_cnt;

   logic [31:0] out2, out_q2;
   logic        sel_q2;
   logic [1:0]  sel_cnt2;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] oq;
      logic        sq;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   exp_t sb[$];

   // Bench model of the state after the most recently scheduled edge.
   logic [31:0] m_oq;
   logic        m_sq;
   logic [15:0] m_cnt;
   logic [1:0]  m_cnt2;

   mux2to1_32 dut (
      .clk     (clk),
      .rst     (rst),
      .sel     (sel),
      .in0     (in0),
      .in1     (in1),
      .out     (out),
      .out_q   (out_q),
      .sel_q   (sel_q),
      .sel_cnt (sel_cnt)
   );

   mux2to1_32 #(.WIDTH(32), .CNT_W(2)) dut2 (
      .clk     (clk),
      .rst     (rst),
      .sel     (sel),
      .in0     (in0),
      .in1     (in1),
      .out     (out2),
      .out_q   (out_q2),
      .sel_q   (sel_q2),
      .sel_cnt (sel_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus just after a rising edge, check the
   // combinational path, schedule the registered expectation, then compare
   // it one time unit after the next rising edge.
   task automatic step(input logic r, input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] e_out;
      exp_t        e;
      rst = r;
      sel = s;
      in0 = a;
      in1 = b;
      #1;
      e_out = s ? b : a;
      check("out", {32'h0, out}, {32'h0, e_out});
      check("out_w2", {32'h0, out2}, {32'h0, e_out});
      if (!r) begin
         m_oq   = '0;
         m_sq   = 1'b0;
         m_cnt  = '0;
         m_cnt2 = '0;
      end else begin
         m_oq = e_out;
         m_sq = s;
         if (s && m_cnt  != 16'hFFFF) m_cnt  = m_cnt + 16'd1;
         if (s && m_cnt2 != 2'd3)     m_cnt2 = m_cnt2 + 2'd1;
      end
      sb.push_back('{oq: m_oq, sq: m_sq, cnt: m_cnt, cnt2: m_cnt2});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("out_q",     {32'h0, out_q},    {32'h0, e.oq});
      check("sel_q",     {63'h0, sel_q},    {63'h0, e.sq});
      check("sel_cnt",   {48'h0, sel_cnt},  {48'h0, e.cnt});
      check("out_q_w2",  {32'h0, out_q2},   {32'h0, e.oq});
      check("sel_cnt_w2",{62'h0, sel_cnt2}, {62'h0, e.cnt2});
   endtask

   initial begin
      rst = 1'b0;
      sel = 1'b0;
      in0 = '0;
      in1 = '0;
      m_oq = '0; m_sq = 1'b0; m_cnt = '0; m_cnt2 = '0;
      @(posedge clk);
      #1;

      // Reset state.
      step(1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      check("reset_cnt_const", {48'h0, sel_cnt}, 64'h0);

      // Basic select, 1-cycle latency on the registered outputs.
      step(1'b1, 1'b0, 32'h0000_0004, 32'h0000_00B0);
      check("pc4_out_q", {32'h0, out_q}, 64'h4);
      step(1'b1, 1'b1, 32'h0000_0004, 32'h0000_00B0);
      check("br_out_q", {32'h0, out_q}, 64'hB0);

      // Reset while counting and sel high: comb path still live, reset wins.
      step(1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
      step(1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
      check("rst_cnt_cleared", {48'h0, sel_cnt}, 64'h0);

      // First edge out of reset updates normally; 5 ones then 3 zeros.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'hA5A5_0000 + i, 32'h5A5A_0000 + i);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'hC0DE_0000 + i, 32'hBEEF_0000 + i);
      check("cnt_five", {48'h0, sel_cnt}, 64'd5);

      // Narrow counter saturates and stays there.
      step(1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 32'h0, 32'h0000_1000 + i);
      check("cnt2_sat", {62'h0, sel_cnt2}, 64'd3);

      // Equal inputs pass through regardless of sel; full-width patterns.
      step(1'b1, 1'b0, 32'h8000_0001, 32'h8000_0001);
      step(1'b1, 1'b1, 32'h8000_0001, 32'h8000_0001);
      step(1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
      step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);

      // rst pulse between edges leaves registered outputs untouched.
      rst = 1'b0;
      #2;
      check("glitch_out_q",   {32'h0, out_q},   {32'h0, m_oq});
      check("glitch_sel_cnt", {48'h0, sel_cnt}, {48'h0, m_cnt});
      rst = 1'b1;
      #1;
      check("glitch_sel_q",   {63'h0, sel_q},   {63'h0, m_sq});

      // Random traffic.
      for (int i = 0; i < 1000; i++) begin
         step(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux2to1_32.md
MUX2TO1_32 -- requirements
Module: mux2to1_32

Interface
REQ-001 Parameter WIDTH, default 32: data width of in0, in1, out and out_q.
REQ-002 Parameter CNT_W, default 16: width of sel_cnt.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-low (asserted when 0, sampled only on rising clk).
REQ-005 Port sel, input, 1 bit: select; 0 chooses in0, 1 chooses in1.
REQ-006 Port in0, input, WIDTH bits: data input 0 (PC+4 path in the IF stage).
REQ-007 Port in1, input, WIDTH bits: data input 1 (branch-target path in the IF stage).
REQ-008 Port out, output, WIDTH bits: combinational mux result.
REQ-009 Port out_q, output, WIDTH bits: registered copy of out.
REQ-010 Port sel_q, output, 1 bit: registered copy of sel.
REQ-011 Port sel_cnt, output, CNT_W bits: saturating count of clock cycles in which sel was 1.
REQ-012 Instantiations of this module SHALL connect ports by name, because clk and rst precede the data ports.

Function
REQ-013 out SHALL equal in1 when sel=1 and in0 when sel=0, with zero latency and no dependence on clk or rst.
REQ-014 out SHALL follow any input change in the same cycle, so that the IF-stage PC register captures the branch target on the edge where sel (BrTaken) is high.
REQ-015 On each rising clk with rst=1, out_q SHALL load the current out value and sel_q SHALL load sel, giving 1-cycle latency.
REQ-016 On each rising clk with rst=1 and sel=1, sel_cnt SHALL increment by 1.
REQ-017 sel_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap to 0.
REQ-018 sel_cnt SHALL hold its value on cycles where sel=0.
REQ-019 When in0 equals in1, out SHALL equal that value regardless of sel.
REQ-020 All WIDTH bits SHALL be passed unmodified, with no sign extension or truncation.
REQ-021 Behaviour when sel is X/Z is unspecified; the bench SHALL NOT drive it.

Reset
REQ-022 When rst=0 at a rising clk, out_q SHALL become 0, sel_q SHALL become 0 and sel_cnt SHALL become 0 on that edge.
REQ-023 While rst=0, out SHALL remain purely combinational and SHALL continue to reflect sel, in0 and in1.
REQ-024 Assertion of rst mid-count SHALL clear sel_cnt on the next rising edge and SHALL override an increment on that same edge.
REQ-025 There SHALL be no asynchronous reset path; rst changes between clock edges SHALL NOT affect the registered outputs.
REQ-026 The first rising edge with rst=1 SHALL perform a normal update.

Verification
REQ-027 sel=0, in0=0x00000004, in1=0x000000B0 -> out=0x00000004 immediately; out_q=0x00000004 after one clock.
REQ-028 sel toggled to 1 with the same inputs -> out=0x000000B0 in the same cycle; sel_q=1 and out_q=0x000000B0 after the next edge.
REQ-029 Hold rst=0 for 2 clocks with sel=1 and in1=0xFFFFFFFF -> out=0xFFFFFFFF throughout; out_q=0, sel_q=0 and sel_cnt=0 after those edges.
REQ-030 After reset, sel=1 for 5 clocks then sel=0 for 3 clocks -> sel_cnt=5.
REQ-031 With CNT_W=2, sel=1 for 6 clocks -> sel_cnt reaches 3 and stays 3.
REQ-032 Random in0, in1 and sel over 1000 cycles -> out always matches the select rule, and out_q matches the previous cycle's out.
